ecc_op_sequencer: RTL and testbench

Control FSM for the ECC datapath (encoder, syndrome calculator, single-error fix stage). Takes a start request with operation code and codeword-width select, then sequences encode, noise injection, syndrome and fix steps. Drives the width flags (Small/Medium) consumed by the fix stage and reports completion and the captured error count. Sits between the AMBA register file and the datapath.

---
 rtl/ecc_pkg.sv | 34 +++
 rtl/ecc_op_sequencer_if.sv | 42 ++++
 rtl/ecc_wait_timer.sv | 32 +++
 rtl/ecc_op_sequencer.sv | 137 +++++++++++++
 tb/tb_ecc_op_sequencer.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC operation sequencer: FSM state encoding,
// operation codes and codeword width codes.
package ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENC   = 3'd1,
    ST_NOISE = 3'd2,
    ST_SYN   = 3'd3,
    ST_FIX   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Operation codes carried on ctrl
  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  // Codeword width codes carried on width_sel (10 and 11 both mean 32-bit)
  localparam logic [1:0] WID_8  = 2'b00;
  localparam logic [1:0] WID_16 = 2'b01;
  localparam logic [1:0] WID_32 = 2'b10;

  function automatic logic op_legal(input logic [1:0] code);
    return code != OP_ILL;
  endfunction

  // Decode and full-channel operations present the decoder result
  function automatic logic op_uses_decoder(input logic [1:0] code);
    return (code == OP_DEC) || (code == OP_FULL);
  endfunction

endpackage

// File: rtl/ecc_op_sequencer_if.sv
// Bundle of request, datapath-status and control/status signals around the
// ECC operation sequencer.
//
// Handshake semantics: start is a single-cycle strobe with no ready; it is
// taken only while busy is low and ctrl is legal, otherwise it is dropped.
// enc_done and syn_done are level-sampled on the rising edge and only while
// the sequencer waits on that particular unit; nof is sampled together with
// syn_done. enc_start, syn_start and operation_done are one-cycle pulses;
// noise_en and fix_load are high for exactly one cycle each.
interface ecc_op_sequencer_if;
  logic       start;
  logic [1:0] ctrl;
  logic [1:0] width_sel;
  logic       enc_done;
  logic       syn_done;
  logic [1:0] nof;
  logic       busy;
  logic       enc_start;
  logic       noise_en;
  logic       syn_start;
  logic       fix_load;
  logic       Small;
  logic       Medium;
  logic       out_sel;
  logic       operation_done;
  logic [1:0] num_of_errors;
  logic       op_timeout;

  // Sequencer side
  modport master (
    input  start, ctrl, width_sel, enc_done, syn_done, nof,
    output busy, enc_start, noise_en, syn_start, fix_load, Small, Medium,
           out_sel, operation_done, num_of_errors, op_timeout
  );

  // Register-file / datapath side
  modport slave (
    output start, ctrl, width_sel, enc_done, syn_done, nof,
    input  busy, enc_start, noise_en, syn_start, fix_load, Small, Medium,
           out_sel, operation_done, num_of_errors, op_timeout
  );
endinterface

// File: rtl/ecc_wait_timer.sv
// Wait-state cycle counter. Cleared when a wait state is entered, counts
// each cycle spent waiting. expired is high in the last allowed waiting
// cycle (count == TIMEOUT-1); a done arriving in that cycle still wins.
module ecc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // Count waiting cycles; hold at the last value rather than wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/ecc_op_sequencer.sv
// Control FSM for the ECC datapath. Sequences encode, noise injection,
// syndrome and single-error fix steps, frames the datapath with the width
// flags and output select, and reports completion, error count and timeout.
module ecc_op_sequencer
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT         = 16
) (
  input  logic                clk,
  input  logic                rst,
  ecc_op_sequencer_if.master  bus,
  output state_t              dbg_state
);

  // Elaboration-time guard on the parameter set
  if (TIMEOUT < 2 || TIMEOUT > 31 || DATA_WIDTH < 1 ||
      AMBA_ADDR_WIDTH < 1 || AMBA_WORD < 1) begin : g_param_check
    $error("ecc_op_sequencer: parameter out of range");
  end

  state_t     state_q;
  state_t     state_d;
  logic [1:0] op_q;
  logic       accept;
  logic       capture_nof;
  logic       timed_out;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_expired;

  ecc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // The timer restarts on every entry into ENC or SYN and runs while waiting
  assign timer_clear  = ((state_d == ST_ENC) && (state_q != ST_ENC)) ||
                        ((state_d == ST_SYN) && (state_q != ST_SYN));
  assign timer_enable = (state_q == ST_ENC) || (state_q == ST_SYN);

  assign dbg_state = state_q;

  // Next-state logic and single-cycle event decode
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture_nof = 1'b0;
    timed_out   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && op_legal(bus.ctrl)) begin
          accept  = 1'b1;
          state_d = (bus.ctrl == OP_DEC) ? ST_SYN : ST_ENC;
        end
      end
      ST_ENC: begin
        if (bus.enc_done) begin
          state_d = (op_q == OP_FULL) ? ST_NOISE : ST_DONE;
        end else if (timer_expired) begin
          state_d   = ST_DONE;
          timed_out = 1'b1;
        end
      end
      ST_NOISE: state_d = ST_SYN;
      ST_SYN: begin
        if (bus.syn_done) begin
          state_d     = ST_FIX;
          capture_nof = 1'b1;
        end else if (timer_expired) begin
          state_d   = ST_DONE;
          timed_out = 1'b1;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q               <= OP_ENC;
      bus.busy           <= 1'b0;
      bus.enc_start      <= 1'b0;
      bus.noise_en       <= 1'b0;
      bus.syn_start      <= 1'b0;
      bus.fix_load       <= 1'b0;
      bus.operation_done <= 1'b0;
      bus.Small          <= 1'b0;
      bus.Medium         <= 1'b0;
      bus.out_sel        <= 1'b0;
      bus.num_of_errors  <= 2'b00;
      bus.op_timeout     <= 1'b0;
    end else begin
      bus.busy           <= (state_d != ST_IDLE);
      bus.enc_start      <= (state_d == ST_ENC) && (state_q != ST_ENC);
      bus.noise_en       <= (state_d == ST_NOISE);
      bus.syn_start      <= (state_d == ST_SYN) && (state_q != ST_SYN);
      bus.fix_load       <= (state_d == ST_FIX);
      bus.operation_done <= (state_d == ST_DONE);
      // Framing and result fields are held until the next accepted start
      if (accept) begin
        op_q              <= bus.ctrl;
        bus.Small         <= (bus.width_sel == WID_8);
        bus.Medium        <= (bus.width_sel == WID_16);
        bus.out_sel       <= op_uses_decoder(bus.ctrl);
        bus.num_of_errors <= 2'b00;
        bus.op_timeout    <= 1'b0;
      end
      if (capture_nof) begin
        bus.num_of_errors <= bus.nof;
      end
      if (timed_out) begin
        bus.op_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Self-checking bench for ecc_op_sequencer.
module tb_ecc_op_sequencer;
  import ecc_pkg::*;

  localparam int TIMEOUT = 16;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t dbg_state;

  ecc_op_sequencer_if bus();

  ecc_op_sequencer #(
    .DATA_WIDTH      (32),
    .AMBA_ADDR_WIDTH (20),
    .AMBA_WORD       (32),
    .TIMEOUT         (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: {op_timeout, num_of_errors} expected per accepted op
  logic [2:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  // Observations from the last run_wait
  state_t trace[64];
  int     done_cycle;
  int     fix_cycle;
  int     fix_cnt;
  int     noise_cnt;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.ctrl      = 2'b00;
    bus.width_sel = 2'b00;
    bus.enc_done  = 1'b0;
    bus.syn_done  = 1'b0;
    bus.nof       = 2'b00;
  endtask

  // Pulses start for one cycle; returns at the negedge of the first op cycle
  task automatic issue_start(input logic [1:0] c, input logic [1:0] w);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.ctrl      = c;
    bus.width_sel = w;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.ctrl      = 2'($urandom_range(0, 3));
    bus.width_sel = 2'($urandom_range(0, 3));
  endtask

  // Cycle c = 0 is the current cycle; done inputs are driven per cycle index
  task automatic run_wait(input int enc_at, input int syn_at, input logic [1:0] nof_v,
                          input bit stray_enc, input int limit);
    done_cycle = -1;
    fix_cycle  = -1;
    fix_cnt    = 0;
    noise_cnt  = 0;
    for (int c = 0; c < limit; c++) begin
      bus.enc_done = stray_enc || (c == enc_at);
      bus.syn_done = (c == syn_at);
      bus.nof      = (c == syn_at) ? nof_v : 2'($urandom_range(0, 3));
      trace[c]     = dbg_state;
      if (bus.fix_load) begin
        fix_cnt++;
        fix_cycle = c;
      end
      if (bus.noise_en) noise_cnt++;
      if (bus.operation_done) begin
        done_cycle = c;
        break;
      end
      @(negedge clk);
    end
    bus.enc_done = 1'b0;
    bus.syn_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] outs;
    drive_idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    outs = {bus.busy, bus.enc_start, bus.noise_en, bus.syn_start, bus.fix_load, bus.Small,
            bus.Medium, bus.out_sel, bus.operation_done, bus.num_of_errors, bus.op_timeout};
    total++;
    if (outs !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", outs, 12'h000);
    end
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_encode();
    logic [2:0] e;
    issue_start(OP_ENC, WID_32);
    exp_q.push_back(3'b000);
    total++;
    if ({bus.enc_start, bus.syn_start, bus.busy} !== 3'b101) begin
      bad++;
      $display("FAIL enc_entry: got %b want 101", {bus.enc_start, bus.syn_start, bus.busy});
    end
    run_wait(3, -1, 2'b00, 1'b0, 24);
    total++;
    if (done_cycle !== 4) begin
      bad++;
      $display("FAIL enc_done_latency: got %0d want 4", done_cycle);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL enc_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if ({bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL enc_result: got %b want %b", {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
    total++;
    if ({bus.out_sel, bus.Small, bus.Medium} !== 3'b000) begin
      bad++;
      $display("FAIL enc_framing: got %b want 000", {bus.out_sel, bus.Small, bus.Medium});
    end
    @(negedge clk);
    total++;
    if ({bus.busy, bus.operation_done} !== 2'b00 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL enc_back_idle: busy/done %b state %0d want 00/%0d",
               {bus.busy, bus.operation_done}, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_decode();
    logic [2:0] e;
    issue_start(OP_DEC, WID_8);
    exp_q.push_back(3'b001);
    total++;
    if ({bus.syn_start, bus.enc_start} !== 2'b10) begin
      bad++;
      $display("FAIL dec_entry: got %b want 10", {bus.syn_start, bus.enc_start});
    end
    run_wait(-1, 2, 2'b01, 1'b1, 24);
    total++;
    if (trace[1] !== ST_SYN || trace[2] !== ST_SYN) begin
      bad++;
      $display("FAIL dec_stray_enc: got %0d,%0d want %0d", trace[1], trace[2], ST_SYN);
    end
    total++;
    if (fix_cnt !== 1 || fix_cycle !== 3) begin
      bad++;
      $display("FAIL dec_fix_load: got cnt %0d at %0d want 1 at 3", fix_cnt, fix_cycle);
    end
    total++;
    if (done_cycle !== 4) begin
      bad++;
      $display("FAIL dec_done_latency: got %0d want 4", done_cycle);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL dec_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if ({bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL dec_result: got %b want %b", {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
    total++;
    if ({bus.Small, bus.Medium, bus.out_sel} !== 3'b101) begin
      bad++;
      $display("FAIL dec_framing: got %b want 101", {bus.Small, bus.Medium, bus.out_sel});
    end
  endtask

  task automatic test_full();
    logic [2:0] e;
    state_t     exp_tr[7];
    exp_tr = '{ST_ENC, ST_ENC, ST_NOISE, ST_SYN, ST_SYN, ST_FIX, ST_DONE};
    issue_start(OP_FULL, WID_16);
    exp_q.push_back(3'b010);
    run_wait(1, 4, 2'b10, 1'b0, 24);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (trace[i] !== exp_tr[i]) begin
        bad++;
        $display("FAIL full_trace[%0d]: got %0d want %0d", i, trace[i], exp_tr[i]);
      end
    end
    total++;
    if (done_cycle !== 6 || noise_cnt !== 1) begin
      bad++;
      $display("FAIL full_timing: done %0d noise %0d want 6 1", done_cycle, noise_cnt);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL full_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if ({bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL full_result: got %b want %b", {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
    total++;
    if ({bus.Small, bus.Medium, bus.out_sel} !== 3'b011) begin
      bad++;
      $display("FAIL full_framing: got %b want 011", {bus.Small, bus.Medium, bus.out_sel});
    end
  endtask

  task automatic test_timeout();
    logic [2:0] e;
    // decode that never sees syn_done
    issue_start(OP_DEC, WID_32);
    exp_q.push_back(3'b100);
    run_wait(-1, -1, 2'b00, 1'b0, 40);
    total++;
    if (done_cycle !== TIMEOUT || fix_cnt !== 0) begin
      bad++;
      $display("FAIL syn_timeout: done %0d fix %0d want %0d 0", done_cycle, fix_cnt, TIMEOUT);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL syn_timeout_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if ({bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL syn_timeout_result: got %b want %b", {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
    // syn_done in the last allowed cycle is honoured
    issue_start(OP_DEC, WID_16);
    exp_q.push_back(3'b011);
    run_wait(-1, TIMEOUT - 1, 2'b11, 1'b0, 40);
    total++;
    if (done_cycle !== TIMEOUT + 1 || fix_cnt !== 1) begin
      bad++;
      $display("FAIL syn_last_cycle: done %0d fix %0d want %0d 1", done_cycle, fix_cnt, TIMEOUT + 1);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL syn_last_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if ({bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL syn_last_result: got %b want %b", {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
    // full op stuck in ENC
    issue_start(OP_FULL, WID_8);
    exp_q.push_back(3'b100);
    run_wait(-1, -1, 2'b00, 1'b0, 40);
    total++;
    if (done_cycle !== TIMEOUT || noise_cnt !== 0 || fix_cnt !== 0) begin
      bad++;
      $display("FAIL enc_timeout: done %0d noise %0d fix %0d want %0d 0 0",
               done_cycle, noise_cnt, fix_cnt, TIMEOUT);
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL enc_timeout_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if ({bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL enc_timeout_result: got %b want %b", {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
  endtask

  task automatic test_ignored();
    logic [2:0] e;
    issue_start(OP_DEC, WID_8);
    exp_q.push_back(3'b001);
    run_wait(-1, 0, 2'b01, 1'b0, 24);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL ign_setup_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if (done_cycle !== 2 || {bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL ign_setup: done %0d result %b want 2 %b",
                 done_cycle, {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
    // illegal ctrl: nothing happens, previous results stay
    issue_start(OP_ILL, WID_16);
    total++;
    if (bus.busy !== 1'b0 || dbg_state !== ST_IDLE || {bus.enc_start, bus.syn_start} !== 2'b00) begin
      bad++;
      $display("FAIL illegal_ctrl: busy %b state %0d starts %b want 0 %0d 00",
               bus.busy, dbg_state, {bus.enc_start, bus.syn_start}, ST_IDLE);
    end
    total++;
    if ({bus.num_of_errors, bus.Small, bus.Medium, bus.out_sel} !== 5'b01101) begin
      bad++;
      $display("FAIL illegal_hold: got %b want 01101",
               {bus.num_of_errors, bus.Small, bus.Medium, bus.out_sel});
    end
    // start while busy in SYN
    issue_start(OP_DEC, WID_32);
    exp_q.push_back(3'b010);
    bus.start     = 1'b1;
    bus.ctrl      = OP_ENC;
    bus.width_sel = WID_8;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (dbg_state !== ST_SYN || bus.enc_start !== 1'b0 ||
        {bus.Small, bus.Medium, bus.out_sel} !== 3'b001) begin
      bad++;
      $display("FAIL busy_start: state %0d enc_start %b framing %b want %0d 0 001",
               dbg_state, bus.enc_start, {bus.Small, bus.Medium, bus.out_sel}, ST_SYN);
    end
    run_wait(-1, 1, 2'b10, 1'b0, 24);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL busy_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if (done_cycle !== 3 || {bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL busy_result: done %0d result %b want 3 %b",
                 done_cycle, {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
    // start held from DONE into IDLE: only the IDLE cycle accepts it
    bus.start     = 1'b1;
    bus.ctrl      = OP_ENC;
    bus.width_sel = WID_16;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL done_start: busy %b state %0d want 0 %0d", bus.busy, dbg_state, ST_IDLE);
    end
    exp_q.push_back(3'b000);
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (dbg_state !== ST_ENC || bus.enc_start !== 1'b1 || bus.Medium !== 1'b1) begin
      bad++;
      $display("FAIL idle_accept: state %0d enc_start %b medium %b want %0d 1 1",
               dbg_state, bus.enc_start, bus.Medium, ST_ENC);
    end
    run_wait(0, -1, 2'b00, 1'b0, 24);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL idle_accept_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if (done_cycle !== 1 || {bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL idle_accept_result: done %0d result %b want 1 %b",
                 done_cycle, {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [2:0]  e;
    logic [11:0] outs;
    int          seen;
    issue_start(OP_DEC, WID_8);
    exp_q.push_back(3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    outs = {bus.busy, bus.enc_start, bus.noise_en, bus.syn_start, bus.fix_load, bus.Small,
            bus.Medium, bus.out_sel, bus.operation_done, bus.num_of_errors, bus.op_timeout};
    total++;
    if (outs !== 12'h000 || dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL mid_reset: outs %b state %0d want 0 %0d", outs, dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      bus.syn_done = 1'b1;
      @(negedge clk);
      if (bus.operation_done || bus.busy) seen++;
    end
    bus.syn_done = 1'b0;
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_reset_no_done: got %0d active cycles want 0", seen);
    end
    issue_start(OP_ENC, WID_16);
    exp_q.push_back(3'b000);
    run_wait(2, -1, 2'b00, 1'b0, 24);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL post_reset_scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      if (done_cycle !== 3 || bus.Medium !== 1'b1 || {bus.op_timeout, bus.num_of_errors} !== e) begin
        bad++;
        $display("FAIL post_reset_op: done %0d medium %b result %b want 3 1 %b",
                 done_cycle, bus.Medium, {bus.op_timeout, bus.num_of_errors}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    logic [1:0] c, w, n;
    int         a, b, enc_at, syn_at, exp_done;
    logic [2:0] exp_frame;
    for (int it = 0; it < 10; it++) begin
      c = 2'($urandom_range(0, 2));
      w = 2'($urandom_range(0, 3));
      n = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 4);
      b = $urandom_range(0, 4);
      if (c == OP_ENC) begin
        enc_at = a;  syn_at = -1;        exp_done = a + 1;
        exp_q.push_back(3'b000);
      end else if (c == OP_DEC) begin
        enc_at = -1; syn_at = b;         exp_done = b + 2;
        exp_q.push_back({1'b0, n});
      end else begin
        enc_at = a;  syn_at = a + 2 + b; exp_done = a + b + 4;
        exp_q.push_back({1'b0, n});
      end
      exp_frame = {w == 2'b00, w == 2'b01, c != OP_ENC};
      issue_start(c, w);
      run_wait(enc_at, syn_at, n, 1'b0, 32);
      total++;
      if (done_cycle !== exp_done) begin
        bad++;
        $display("FAIL b2b_latency[%0d]: ctrl %0d got %0d want %0d", it, c, done_cycle, exp_done);
      end
      total++;
      if ({bus.Small, bus.Medium, bus.out_sel} !== exp_frame) begin
        bad++;
        $display("FAIL b2b_framing[%0d]: got %b want %b", it, {bus.Small, bus.Medium, bus.out_sel}, exp_frame);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL b2b_scoreboard[%0d]: queue empty", it);
      end else begin
        e = exp_q.pop_front();
        if ({bus.op_timeout, bus.num_of_errors} !== e) begin
          bad++;
          $display("FAIL b2b_result[%0d]: got %b want %b", it, {bus.op_timeout, bus.num_of_errors}, e);
        end
      end
    end
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Main sequence and final report
  initial begin
    test_reset();
    test_encode();
    test_decode();
    test_full();
    test_timeout();
    test_ignored();
    test_reset_mid_op();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
